// File: rtl/ram_portb_arbiter.sv
// Port-B arbiter for the single-cycle-read RAM: round-robin between the CPU LSU (m0)
// and the loader/debug master (m1), with an m1 lock and read-modify-write for sub-word stores.
module ram_portb_arbiter #(
  parameter int ADDR_W      = 32,
  parameter bit FIRST_GRANT = 1'b0,
  parameter bit ENABLE_RMW  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [3:0]        m0_be,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_ack,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_be,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_ack,
  output logic [31:0]       m1_rdata,
  input  logic              m1_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_web,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, ACCESS, RD_WAIT, MERGE, WRITE} state_t;

  state_t      state;
  logic        last_grant;
  logic        sel_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic              r0, r1;
  logic              grant_vld, grant_sel;
  logic [3:0]        gnt_be;
  logic [ADDR_W-1:0] gnt_addr;
  logic [31:0]       gnt_wdata;
  logic              gnt_direct;

  function automatic logic [31:0] merge_lanes(input logic [3:0] be,
                                              input logic [31:0] wdata,
                                              input logic [31:0] rdata);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    return res;
  endfunction

  // A request seen in its own ack cycle is the one just completed, so it cannot win again.
  assign r0 = m0_req & ~m0_ack;
  assign r1 = m1_req & ~m1_ack;

  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    if (m1_lock && last_grant && r1) begin
      grant_vld = 1'b1;
      grant_sel = 1'b1;
    end else if (m1_lock && last_grant && m1_ack) begin
      // Locked m1 just finished: hold one cycle so a follow-on m1 request keeps the port.
      grant_vld = 1'b0;
    end else if (r0 && r1) begin
      grant_vld = 1'b1;
      grant_sel = ~last_grant;
    end else if (r0 || r1) begin
      grant_vld = 1'b1;
      grant_sel = r1;
    end
  end

  assign gnt_be     = grant_sel ? m1_be    : m0_be;
  assign gnt_addr   = grant_sel ? m1_addr  : m0_addr;
  assign gnt_wdata  = grant_sel ? m1_wdata : m0_wdata;
  assign gnt_direct = (gnt_be == 4'hF) || (!ENABLE_RMW && gnt_be != 4'h0);

  // Captured transaction fields; only meaningful outside IDLE, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && grant_vld) begin
      sel_q   <= grant_sel;
      be_q    <= gnt_be;
      wdata_q <= gnt_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= ~FIRST_GRANT;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      ram_addr   <= '0;
      ram_web    <= '0;
      ram_din    <= '0;
      busy       <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_vld) begin
            last_grant <= grant_sel;
            ram_addr   <= gnt_addr & {{(ADDR_W-2){1'b1}}, 2'b00};
            ram_web    <= gnt_direct ? gnt_be : 4'h0;
            ram_din    <= gnt_wdata;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (be_q == 4'h0) begin
            state <= RD_WAIT;
          end else if (be_q == 4'hF || !ENABLE_RMW) begin
            ram_web <= 4'h0;
            m0_ack  <= ~sel_q;
            m1_ack  <= sel_q;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            state <= MERGE;
          end
        end
        RD_WAIT: begin
          if (sel_q) m1_rdata <= ram_dout;
          else       m0_rdata <= ram_dout;
          m0_ack <= ~sel_q;
          m1_ack <= sel_q;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        MERGE: begin
          ram_din <= merge_lanes(be_q, wdata_q, ram_dout);
          ram_web <= 4'hF;
          state   <= WRITE;
        end
        WRITE: begin
          ram_web <= 4'h0;
          m0_ack  <= ~sel_q;
          m1_ack  <= sel_q;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Directed bench for ram_portb_arbiter: a byte-lane RAM model behind the default instance,
// plus a second instance with read-modify-write disabled.
module tb_ram_portb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m1_lock;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack, busy;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] ram_addr, ram_din, ram_dout;
  logic [3:0]  ram_web;

  logic        d_m0_req, d_m1_req, d_m1_lock;
  logic [3:0]  d_m0_be, d_m1_be;
  logic [31:0] d_m0_addr, d_m1_addr, d_m0_wdata, d_m1_wdata;
  logic        d_m0_ack, d_m1_ack, d_busy;
  logic [31:0] d_m0_rdata, d_m1_rdata;
  logic [31:0] d_ram_addr, d_ram_din, d_ram_dout;
  logic [3:0]  d_ram_web;

  int n_chk = 0;
  int n_pass = 0;

  int          t_lat, t_nweb, t_other;
  logic [3:0]  t_web1;
  logic        t_busy1;
  logic [31:0] t_din, t_waddr, t_rdata;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  ram_portb_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_lock(m1_lock),
    .ram_addr(ram_addr), .ram_web(ram_web), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  ram_portb_arbiter #(.ADDR_W(32), .FIRST_GRANT(1'b0), .ENABLE_RMW(1'b0)) dut_d (
    .clk(clk), .reset(reset),
    .m0_req(d_m0_req), .m0_be(d_m0_be), .m0_addr(d_m0_addr), .m0_wdata(d_m0_wdata),
    .m0_ack(d_m0_ack), .m0_rdata(d_m0_rdata),
    .m1_req(d_m1_req), .m1_be(d_m1_be), .m1_addr(d_m1_addr), .m1_wdata(d_m1_wdata),
    .m1_ack(d_m1_ack), .m1_rdata(d_m1_rdata), .m1_lock(d_m1_lock),
    .ram_addr(d_ram_addr), .ram_web(d_ram_web), .ram_din(d_ram_din), .ram_dout(d_ram_dout),
    .busy(d_busy)
  );

  assign d_ram_dout = 32'h0;

  // Synchronous RAM, byte write enables, registered read data.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_web[i]) mem[ram_addr[9:2]][8*i +: 8] <= ram_din[8*i +: 8];
    ram_dout <= mem[ram_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issue one transaction from master m starting at a negedge; trace it until ack.
  task automatic txn(input bit m, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata);
    if (m) begin m1_req = 1'b1; m1_be = be; m1_addr = addr; m1_wdata = wdata; end
    else   begin m0_req = 1'b1; m0_be = be; m0_addr = addr; m0_wdata = wdata; end
    t_lat = 0; t_nweb = 0; t_other = 0; t_web1 = 4'h0; t_busy1 = 1'b0;
    t_din = 32'h0; t_waddr = 32'h0; t_rdata = 32'h0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin t_web1 = ram_web; t_busy1 = busy; end
      if (ram_web != 4'h0) begin t_nweb++; t_din = ram_din; t_waddr = ram_addr; end
      if (m ? m0_ack : m1_ack) t_other++;
      if (m ? m1_ack : m0_ack) begin
        t_lat = n;
        t_rdata = m ? m1_rdata : m0_rdata;
        break;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int q[$];
    int acks;
    reset = 1'b1;
    m0_req = 0; m0_be = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_be = 0; m1_addr = 0; m1_wdata = 0; m1_lock = 0;
    d_m0_req = 0; d_m0_be = 0; d_m0_addr = 0; d_m0_wdata = 0;
    d_m1_req = 0; d_m1_be = 0; d_m1_addr = 0; d_m1_wdata = 0; d_m1_lock = 0;
    repeat (2) @(negedge clk);
    chk("rst_web", ram_web, 4'h0);
    chk("rst_addr", ram_addr, 32'h0);
    chk("rst_din", ram_din, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acks", {m0_ack, m1_ack}, 2'b00);
    chk("rst_rdata0", m0_rdata, 32'h0);
    chk("rst_rdata1", m1_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    chk("pre_lat", t_lat, 2);
    txn(1'b0, 4'h0, 32'h10, 32'h0);
    chk("rd_lat", t_lat, 3);
    chk("rd_data", t_rdata, 32'hDEADBEEF);
    chk("rd_noweb", t_nweb, 0);
    chk("rd_other", t_other, 0);
    chk("rd_busy", t_busy1, 1'b1);

    txn(1'b1, 4'hF, 32'h20, 32'h12345678);
    chk("wr_lat", t_lat, 2);
    chk("wr_nweb", t_nweb, 1);
    chk("wr_addr", t_waddr, 32'h20);
    chk("wr_din", t_din, 32'h12345678);
    txn(1'b0, 4'h0, 32'h23, 32'h0);
    chk("wr_readback", t_rdata, 32'h12345678);

    txn(1'b0, 4'b0010, 32'h20, 32'h0000AB00);
    chk("rmw_lat", t_lat, 4);
    chk("rmw_rdcyc", t_web1, 4'h0);
    chk("rmw_nweb", t_nweb, 1);
    chk("rmw_din", t_din, 32'h1234AB78);
    txn(1'b1, 4'h0, 32'h20, 32'h0);
    chk("rmw_readback", t_rdata, 32'h1234AB78);
    chk("rmw_rdlat", t_lat, 3);

    // Round-robin from reset: both masters read continuously.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0_be = 0; m0_addr = 32'h10; m1_be = 0; m1_addr = 32'h20;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 80 && q.size() < 6; c++) begin
      @(negedge clk);
      if (m0_ack) q.push_back(0);
      if (m1_ack) q.push_back(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    chk("arb_count", q.size(), 6);
    for (int i = 0; i < q.size(); i++) chk($sformatf("arb_order%0d", i), q[i], i % 2);
    repeat (4) @(negedge clk);

    // Lock held by m1 (last grant): m1 keeps the port until the lock drops.
    q.delete();
    m1_lock = 1'b1;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int c = 0; c < 80 && q.size() < 4; c++) begin
      @(negedge clk);
      if (m0_ack) q.push_back(0);
      if (m1_ack) q.push_back(1);
      if (q.size() == 3) m1_lock = 1'b0;
    end
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    chk("lock_count", q.size(), 4);
    for (int i = 0; i < q.size(); i++) chk($sformatf("lock_order%0d", i), q[i], (i < 3) ? 1 : 0);
    repeat (4) @(negedge clk);

    // Reset during the write phase of a byte RMW must not commit the word.
    txn(1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
    m0_req = 1'b1; m0_be = 4'b0001; m0_addr = 32'h30; m0_wdata = 32'h000000AA;
    repeat (3) @(negedge clk);
    chk("mid_inwrite", ram_web, 4'hF);
    reset = 1'b1;
    #1;
    chk("mid_web", ram_web, 4'h0);
    chk("mid_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m0_req = 1'b0;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (m0_ack || m1_ack) acks++;
    end
    chk("mid_noack", acks, 0);
    txn(1'b1, 4'h0, 32'h30, 32'h0);
    chk("mid_intact", t_rdata, 32'hCAFEF00D);

    // Direct partial write with read-modify-write disabled.
    d_m0_req = 1'b1; d_m0_be = 4'b1100; d_m0_addr = 32'h40; d_m0_wdata = 32'hAABB0000;
    t_lat = 0; t_nweb = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        chk("dir_web", d_ram_web, 4'b1100);
        chk("dir_addr", d_ram_addr, 32'h40);
        chk("dir_din", d_ram_din, 32'hAABB0000);
        chk("dir_busy", d_busy, 1'b1);
      end
      if (d_ram_web != 4'h0) t_nweb++;
      if (d_m1_ack) chk("dir_m1ack", d_m1_ack, 1'b0);
      if (d_m0_ack) begin t_lat = n; break; end
    end
    d_m0_req = 1'b0;
    chk("dir_lat", t_lat, 2);
    chk("dir_nweb", t_nweb, 1);
    chk("dir_rdata", {d_m0_rdata | d_m1_rdata}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
